// File: rtl/instr_mem_responder.sv
// Instruction memory responder.
//
// Serves 19-bit instruction words for a CPU word address (pc). A fetch for a
// new pc takes READ_LATENCY cycles; busywait stays high until instruction
// corresponds to the current pc. A loader port writes words into the array
// whenever the responder is idle and serving a valid pc.
//
// Optional build macro IMEM_PREFETCH_EN: every completed fetch also captures
// the word at pc+1 into a one-entry buffer, so a sequential fetch completes
// in a single cycle.
//
// state | meaning
// IDLE  | serving served_pc (if served_valid); accepts misses and loads
// READ  | fetching req_pc; counter runs down to completion
// WRITE | committing the latched loader word on the next edge
module instr_mem_responder #(
    parameter int DEPTH        = 128,
    parameter int READ_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic [18:0] instruction,
    output logic        busywait,
    output logic        addr_err,
    input  logic        load_en,
    input  logic [6:0]  load_addr,
    input  logic [18:0] load_data,
    output logic        load_ack
);

    localparam logic [2:0] LAT_LOAD = 3'(READ_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  count;
    logic [2:0]  count_nxt;
    logic [31:0] req_pc;
    logic [31:0] req_pc_nxt;
    logic [31:0] served_pc;
    logic        served_valid;
    logic [6:0]  wr_addr;
    logic [18:0] wr_data;

    logic [18:0] mem [DEPTH];

    logic        hit;
    logic        fill;
    logic [31:0] fill_pc;
    logic [18:0] fill_word;
    logic        fill_err;
    logic        commit;
    logic        latch_wr;
    logic        wr_hits_served;

    assign hit            = served_valid && (pc == served_pc);
    assign busywait       = !hit || (state != S_IDLE);
    assign fill_err       = |fill_pc[31:7];
    assign wr_hits_served = (wr_addr == served_pc[6:0]) && (served_pc[31:7] == '0);

`ifdef IMEM_PREFETCH_EN
    logic        pf_valid;
    logic [31:0] pf_tag;
    logic [18:0] pf_data;
    logic        pf_hit;
    logic        fill_pf;
    logic [31:0] pf_next_pc;
    logic [18:0] pf_word;

    assign pf_hit     = pf_valid && (pc == pf_tag);
    assign pf_next_pc = fill_pc + 32'd1;
    assign pf_word    = (|pf_next_pc[31:7]) ? 19'h0 : mem[pf_next_pc[6:0]];
`endif

    // Next-state, counter and fetch/commit control.
    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        req_pc_nxt = req_pc;
        fill       = 1'b0;
        fill_pc    = req_pc;
        commit     = 1'b0;
        latch_wr   = 1'b0;
`ifdef IMEM_PREFETCH_EN
        fill_pf    = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (!hit) begin
`ifdef IMEM_PREFETCH_EN
                    if (pf_hit) begin
                        fill    = 1'b1;
                        fill_pc = pc;
                        fill_pf = 1'b1;
                    end else
`endif
                    // A one-cycle latency leaves no room for a READ cycle,
                    // so the fetch completes straight from IDLE.
                    if (READ_LATENCY == 1) begin
                        fill    = 1'b1;
                        fill_pc = pc;
                    end else begin
                        state_nxt  = S_READ;
                        req_pc_nxt = pc;
                        count_nxt  = LAT_LOAD;
                    end
                end else if (load_en && !load_ack) begin
                    // load_ack high means the loader has not yet dropped
                    // load_en for the write just committed.
                    state_nxt = S_WRITE;
                    latch_wr  = 1'b1;
                end
            end
            S_READ: begin
                if (pc != req_pc) begin
                    req_pc_nxt = pc;
                    count_nxt  = LAT_LOAD;
                end else if (count <= 3'd1) begin
                    fill      = 1'b1;
                    fill_pc   = req_pc;
                    count_nxt = 3'd0;
                    state_nxt = S_IDLE;
                end else begin
                    count_nxt = count - 3'd1;
                end
            end
            S_WRITE: begin
                commit    = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

`ifdef IMEM_PREFETCH_EN
    // Word delivered on completion: from the prefetch buffer or the array.
    always_comb begin
        fill_word = mem[fill_pc[6:0]];
        if (fill_err)
            fill_word = 19'h0;
        else if (fill_pf)
            fill_word = pf_data;
    end
`else
    // Word delivered on completion, zero for out-of-range addresses.
    always_comb begin
        fill_word = mem[fill_pc[6:0]];
        if (fill_err)
            fill_word = 19'h0;
    end
`endif

    // State, counter, served-pc tracking and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= S_IDLE;
            count        <= 3'd0;
            instruction  <= 19'h0;
            addr_err     <= 1'b0;
            load_ack     <= 1'b0;
            served_valid <= 1'b0;
        end else begin
            state    <= state_nxt;
            count    <= count_nxt;
            req_pc   <= req_pc_nxt;
            load_ack <= commit;
            if (latch_wr) begin
                wr_addr <= load_addr;
                wr_data <= load_data;
            end
            if (fill) begin
                instruction  <= fill_word;
                addr_err     <= fill_err;
                served_pc    <= fill_pc;
                served_valid <= 1'b1;
            end else if (commit && wr_hits_served) begin
                served_valid <= 1'b0;
            end
        end
    end

    // Instruction array; contents survive reset, and a write pending when
    // reset arrives is dropped.
    always_ff @(posedge clk) begin
        if (reset && commit)
            mem[wr_addr] <= wr_data;
    end

`ifdef IMEM_PREFETCH_EN
    // One-entry prefetch buffer, refilled on every completion and dropped
    // when the loader overwrites the word it holds.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pf_valid <= 1'b0;
        end else if (fill) begin
            pf_valid <= 1'b1;
            pf_tag   <= pf_next_pc;
            pf_data  <= pf_word;
        end else if (commit && (pf_tag[31:7] == '0) && (pf_tag[6:0] == wr_addr)) begin
            pf_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_instr_mem_responder.sv
// Testbench for instr_mem_responder: directed boundary cases followed by a
// randomized mix of pc changes and loader writes, checked against a plain
// array model of the instruction memory.
`timescale 1ns/1ps
module tb_instr_mem_responder;

`ifdef IMEM_PREFETCH_EN
    localparam int SEQ_LAT = 1;
`else
    localparam int SEQ_LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pc = 32'h0;
    logic [18:0] instruction;
    logic        busywait;
    logic        addr_err;
    logic        load_en = 1'b0;
    logic [6:0]  load_addr = 7'h0;
    logic [18:0] load_data = 19'h0;
    logic        load_ack;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [18:0] ref_mem [128];
    bit          mon_en = 1'b0;

    always #5 clk = ~clk;

    instr_mem_responder dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .instruction (instruction),
        .busywait    (busywait),
        .addr_err    (addr_err),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .load_ack    (load_ack)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [18:0] exp_instr(input logic [31:0] a);
        if (a[31:7] != 25'h0)
            return 19'h0;
        return ref_mem[a[6:0]];
    endfunction

    // Whenever the responder claims to be serving pc, its word must match
    // the model.
    always @(negedge clk) begin
        if (mon_en && reset && !busywait) begin
            chk("mon_instr", 32'(instruction), 32'(exp_instr(pc)));
            chk("mon_err", 32'(addr_err), 32'(pc[31:7] != 25'h0));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag, output int n);
        bit done;
        done = 1'b0;
        n = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (busywait) n++;
            else done = 1'b1;
        end
        if (!done) chk({tag, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic set_pc(input logic [31:0] a);
        tick();
        pc = a;
    endtask

    task automatic step(input logic [31:0] a, input int lat, input string tag);
        int n;
        set_pc(a);
        wait_idle(tag, n);
        chk({tag, "_lat"}, 32'(n), 32'(lat));
        chk({tag, "_instr"}, 32'(instruction), 32'(exp_instr(a)));
    endtask

    task automatic do_load(input logic [6:0] a, input logic [18:0] d, output bit busy_at_ack);
        bit got;
        got = 1'b0;
        busy_at_ack = 1'b0;
        tick();
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (load_ack) begin
                got = 1'b1;
                busy_at_ack = busywait;
            end
        end
        if (!got) chk("load_ack_timeout", 32'd1, 32'd0);
        tick();
        load_en = 1'b0;
        if (got) ref_mem[a] = d;
        @(negedge clk);
        chk("ack_pulse", 32'(load_ack), 32'd0);
    endtask

    function automatic logic [31:0] rand_pc(input logic [31:0] cur);
        int sel;
        sel = $urandom_range(0, 7);
        if (sel == 0) return {25'($urandom_range(1, 3)), 7'($urandom)};
        if (sel <= 2) return cur + 32'd1;
        return {25'h0, 7'($urandom)};
    endfunction

    initial begin
        int          n;
        bit          b;
        bit          done;
        logic [18:0] d;
        logic [6:0]  a;
        logic [18:0] old10;

        // Reset state
        @(posedge clk);
        @(negedge clk);
        chk("rst_instr", 32'(instruction), 32'd0);
        chk("rst_err", 32'(addr_err), 32'd0);
        chk("rst_ack", 32'(load_ack), 32'd0);
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk("first_busy", 32'(busywait), 32'd1);
        wait_idle("boot", n);

        // Fill the whole array through the loader with distinct words
        for (int i = 0; i < 128; i++) begin
            if (i < 2) d = 19'h40441;
            else d = {12'($urandom), 7'(i)};
            do_load(7'(i), d, b);
        end
        wait_idle("fill", n);
        mon_en = 1'b1;

        // One-cycle reset pulse with pc=0
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        wait_idle("rst_pulse", n);
        chk("rst_pulse_lat", 32'(n), 32'd2);
        chk("rst_pulse_instr", 32'(instruction), 32'h40441);

        // Sequential steps
        step(32'd1, SEQ_LAT, "seq1");
        step(32'd2, SEQ_LAT, "seq2");

        // pc change mid-READ aborts the first fetch
        set_pc(32'd5);
        set_pc(32'd9);
        n = 0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            chk("no_stale5", 32'(instruction == ref_mem[5]), 32'd0);
            if (busywait) n++;
            else done = 1'b1;
        end
        if (!done) chk("abort_timeout", 32'd1, 32'd0);
        chk("abort_lat", 32'(n), 32'd2);
        chk("abort_instr", 32'(instruction), 32'(ref_mem[9]));

        // Load over the served word forces a refetch
        step(32'd3, 2, "pc3");
        do_load(7'd3, 19'h7FFFF, b);
        chk("load_busy", 32'(b), 32'd1);
        wait_idle("reload", n);
        chk("reload_instr", 32'(instruction), 32'h7FFFF);

        // Out-of-range pc
        step(32'h80, 2, "pc80");
        chk("pc80_err", 32'(addr_err), 32'd1);
        step(32'h0, 2, "pc0");
        chk("pc0_err", 32'(addr_err), 32'd0);

        // Reset during WRITE must not commit
        old10 = ref_mem[10];
        tick();
        load_en   = 1'b1;
        load_addr = 7'd10;
        load_data = ~old10;
        tick();
        reset   = 1'b0;
        load_en = 1'b0;
        @(negedge clk);
        chk("wr_state_busy", 32'(busywait), 32'd1);
        chk("wr_ack_a", 32'(load_ack), 32'd0);
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk("wr_ack_b", 32'(load_ack), 32'd0);
        wait_idle("wr_abort", n);
        step(32'd10, 2, "pc10");
        chk("mem10_kept", 32'(instruction), 32'(old10));

        // Randomized mix
        for (int it = 0; it < 150; it++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op < 5) begin
                set_pc(rand_pc(pc));
                wait_idle("rnd_pc", n);
                chk("rnd_instr", 32'(instruction), 32'(exp_instr(pc)));
                chk("rnd_err", 32'(addr_err), 32'(pc[31:7] != 25'h0));
            end else if (op < 8) begin
                if ($urandom_range(0, 1) == 0) a = pc[6:0] + 7'($urandom_range(0, 1));
                else a = 7'($urandom);
                do_load(a, 19'($urandom), b);
                wait_idle("rnd_load", n);
                chk("rnd_load_instr", 32'(instruction), 32'(exp_instr(pc)));
            end else begin
                set_pc(rand_pc(pc));
                repeat ($urandom_range(0, 2)) @(negedge clk);
                set_pc(rand_pc(pc));
                wait_idle("rnd_abort", n);
                chk("rnd_abort_instr", 32'(instruction), 32'(exp_instr(pc)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/instr_mem_responder.md
INSTR_MEM_RESPONDER -- requirements
Module: instr_mem_responder

Interface
REQ-001 Parameter DEPTH, default 128: instruction words held; address width 7.
REQ-002 Parameter READ_LATENCY, default 2: cycles from miss detection to INSTRUCTION update; legal range 1..7.
REQ-003 CLK  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 RESET  input  1  synchronous, active-low reset; sampled only on the rising edge of CLK.
REQ-005 PC  input  32  word address from the CPU; PC[6:0] SHALL index the array.
REQ-006 INSTRUCTION  output  19  registered instruction word for the served PC.
REQ-007 BUSYWAIT  output  1  high while INSTRUCTION does not correspond to the current PC.
REQ-008 ADDR_ERR  output  1  registered; high while the served PC has PC[31:7] != 0.
REQ-009 LOAD_EN  input  1  loader write request.
REQ-010 LOAD_ADDR  input  7  loader word address.
REQ-011 LOAD_DATA  input  19  loader word.
REQ-012 LOAD_ACK  output  1  one-cycle pulse when a loader write commits.

Function
REQ-013 The block SHALL keep served_pc (32 b) and served_valid (1 b).
REQ-014 hit = served_valid AND (PC == served_pc). BUSYWAIT SHALL equal NOT hit OR (state != IDLE), combinationally.
REQ-015 FSM states SHALL be IDLE, READ and WRITE.
REQ-016 IDLE, miss: go to READ, latch PC into req_pc, load the counter with READ_LATENCY-1.
REQ-017 READ: decrement the counter each cycle. At 0, set INSTRUCTION to mem[req_pc[6:0]] (or 19'b0 if req_pc[31:7] != 0). Set served_pc = req_pc, served_valid = 1 and ADDR_ERR, then return to IDLE.
REQ-018 Miss latency: PC changes in cycle N; INSTRUCTION valid and BUSYWAIT low in cycle N+READ_LATENCY.
REQ-019 PC change while in READ: abort, relatch req_pc, restart the full count; INSTRUCTION holds its old value.
REQ-020 IDLE, hit, LOAD_EN high: go to WRITE. Commit mem[LOAD_ADDR] = LOAD_DATA on the next edge, pulse LOAD_ACK, return to IDLE.
REQ-021 A miss has priority over LOAD_EN. LOAD_EN SHALL be held by the loader until LOAD_ACK; a load is never dropped.
REQ-022 Write with LOAD_ADDR == served_pc[6:0] and served_pc[31:7] == 0: clear served_valid. This forces a refetch, so stale code is never served.
REQ-023 Loads to any address SHALL be accepted; addresses wrap modulo DEPTH.

Reset
REQ-024 On a rising edge with RESET low: state = IDLE, INSTRUCTION = 0, ADDR_ERR = 0, LOAD_ACK = 0, served_valid = 0, counter = 0.
REQ-025 Array contents SHALL NOT be reset.
REQ-026 Reset during READ or WRITE SHALL abandon the operation; an in-flight WRITE SHALL NOT commit.
REQ-027 The first cycle after reset release with any PC SHALL show BUSYWAIT high.

Configuration
REQ-028 Macro IMEM_PREFETCH_EN. When defined, on every READ completion the block SHALL also capture mem[req_pc+1] into a one-entry buffer tagged req_pc+1.
REQ-029 With IMEM_PREFETCH_EN, a miss matching a valid tag SHALL complete in 1 cycle (INSTRUCTION updated on the next edge).
REQ-030 With IMEM_PREFETCH_EN, a load to the tagged address SHALL invalidate the buffer.
REQ-031 Without IMEM_PREFETCH_EN, every miss SHALL take READ_LATENCY cycles and no buffer SHALL exist.

Verification
REQ-032 Load mem[0]=19'h40441 and mem[1]=19'h40441, then pulse RESET low for 1 cycle with PC=0 -> BUSYWAIT high 2 cycles, then INSTRUCTION=19'h40441 and BUSYWAIT low.
REQ-033 PC steps 0 to 1 to 2 with prefetch off -> each step BUSYWAIT high exactly 2 cycles. With IMEM_PREFETCH_EN -> steps 0 to 1 and 1 to 2 each BUSYWAIT high exactly 1 cycle.
REQ-034 PC=5 mid-READ, change to 9 after 1 cycle -> INSTRUCTION = mem[9] 2 cycles after the change; mem[5] never appears.
REQ-035 PC=3 served, then LOAD_EN with LOAD_ADDR=3 and LOAD_DATA=19'h7FFFF -> LOAD_ACK pulses, BUSYWAIT rises, and INSTRUCTION = 19'h7FFFF after 2 cycles.
REQ-036 PC=32'h80 -> after latency INSTRUCTION=0, ADDR_ERR=1. Then PC=0 -> ADDR_ERR=0.
REQ-037 RESET low during WRITE to address 10 -> mem[10] unchanged, LOAD_ACK not pulsed.
